led_shift_engine: RTL and testbench

Parametrised successor to the 8-bit LED shift register. It is a WIDTH-bit register with synchronous clear and parallel load. It supports logical shifts, rotations, arithmetic shift right, and a bouncing "ping-pong" mode. Shifts are triggered either by an edge-detected manual step or by an internal programmable-rate tick. The output drives the board LED bank directly.

---
 rtl/led_shift_pkg.sv | 24 ++
 rtl/led_shift_engine_tick_prescaler.sv | 37 +++
 rtl/led_shift_engine.sv | 115 +++++++++++
 tb/tb_led_shift_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_shift_pkg.sv
// Shared types and defaults for the LED shift engine.
package led_shift_pkg;

    // Shift mode selected on the mode port. RSVD behaves like HOLD.
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        SHL    = 3'd1,
        SHR    = 3'd2,
        ROL    = 3'd3,
        ROR    = 3'd4,
        ASR    = 3'd5,
        BOUNCE = 3'd6,
        RSVD   = 3'd7
    } shift_mode_e;

    // Travel direction of the lit pattern in BOUNCE mode.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int DIV_W_DEFAULT = 24;

endpackage

// File: rtl/led_shift_engine_tick_prescaler.sv
// Programmable-rate strobe generator: tick is high for one cycle every
// div+1 cycles while en is high. The counter restarts from zero on clear
// or whenever en drops, so the first tick after enabling always arrives
// a full period later.
module tick_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // Count up to div, then wrap to zero and raise the registered strobe.
    // An equality compare (not >=) lets a count left above a newly lowered
    // div run on through the natural wrap before it hits div again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear || !en) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == div) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + DIV_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/led_shift_engine.sv
// WIDTH-bit LED shift register with clear, parallel load, shift/rotate
// modes and a bouncing mode. Shifts happen on a rising edge of step or on
// a prescaler tick while auto_en is high. All outputs come from flops.
module led_shift_engine
    import led_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    input  logic             step,
    input  logic             auto_en,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tick
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    dir_e             dir_r;
    dir_e             dir_next;
    logic             step_d;
    logic             step_evt;
    logic             evt;
    logic             prescale_tick;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (auto_en),
        .div   (div),
        .tick  (prescale_tick)
    );

    // A held step produces a single event on its rising edge only.
    assign step_evt = step & ~step_d;
    assign evt      = step_evt | (auto_en & prescale_tick);

    assign q    = q_r;
    assign dir  = dir_r;
    assign tick = prescale_tick;

    // Remember last cycle's step level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_d <= 1'b0;
        end else begin
            step_d <= step;
        end
    end

    // Next pattern and direction if a shift event is applied this cycle.
    always_comb begin
        q_next   = q_r;
        dir_next = dir_r;
        case (shift_mode_e'(mode))
            SHL:    q_next = {q_r[WIDTH-2:0], serial_in};
            SHR:    q_next = {serial_in, q_r[WIDTH-1:1]};
            ROL:    q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            ROR:    q_next = {q_r[0], q_r[WIDTH-1:1]};
            ASR:    q_next = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            BOUNCE: begin
                // Reverse when the pattern touches the end it is moving
                // toward; the reversing step already moves one place back.
                if (dir_r == DIR_LEFT) begin
                    if (q_r[WIDTH-1]) begin
                        dir_next = DIR_RIGHT;
                        q_next   = q_r >> 1;
                    end else begin
                        q_next   = q_r << 1;
                    end
                end else begin
                    if (q_r[0]) begin
                        dir_next = DIR_LEFT;
                        q_next   = q_r << 1;
                    end else begin
                        q_next   = q_r >> 1;
                    end
                end
            end
            default: begin
                q_next   = q_r;
                dir_next = dir_r;
            end
        endcase
    end

    // Register update: clear beats load, load beats a shift event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            dir_r <= DIR_LEFT;
        end else if (clear) begin
            q_r   <= '0;
            dir_r <= DIR_LEFT;
        end else if (load) begin
            q_r   <= din;
            dir_r <= DIR_LEFT;
        end else if (evt) begin
            q_r   <= q_next;
            dir_r <= dir_next;
        end
    end

endmodule

// File: tb/tb_led_shift_engine.sv
// Directed and randomized bench for led_shift_engine (WIDTH=8, DIV_W=24).
module tb_led_shift_engine;

    localparam int W  = 8;
    localparam int DW = 24;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  din = '0;
    logic [2:0]    mode = 3'd0;
    logic          serial_in = 1'b0;
    logic          step = 1'b0;
    logic          auto_en = 1'b0;
    logic [DW-1:0] div = '0;
    logic [W-1:0]  q;
    logic          dir;
    logic          tick;

    always #5 clk = ~clk;

    led_shift_engine #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (load),
        .din       (din),
        .mode      (mode),
        .serial_in (serial_in),
        .step      (step),
        .auto_en   (auto_en),
        .div       (div),
        .q         (q),
        .dir       (dir),
        .tick      (tick)
    );

    // ---------------- reference model ----------------
    logic [W-1:0]  m_q;
    logic          m_dir;
    logic          m_tick;
    logic          m_step_d;
    logic [DW-1:0] m_cnt;
    logic [W-1:0]  exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        m_q = '0; m_dir = 1'b0; m_tick = 1'b0; m_step_d = 1'b0; m_cnt = '0;
        exp_q.delete();
    endtask

    // Next LED pattern from the mode rules, using integer arithmetic.
    task automatic apply_mode(input int unsigned v, input int unsigned md,
                              output int unsigned nv, inout logic nd);
        int unsigned mask;
        int unsigned top;
        mask = (32'd1 << W) - 1;
        top  = 32'd1 << (W - 1);
        nv = v;
        case (md)
            1: nv = ((v * 2) & mask) | 32'(serial_in);
            2: nv = (v / 2) | (serial_in ? top : 0);
            3: nv = ((v * 2) & mask) | ((v & top) != 0 ? 1 : 0);
            4: nv = (v / 2) | ((v % 2) != 0 ? top : 0);
            5: nv = (v / 2) | (v & top);
            6: begin
                if (nd == 1'b0) begin
                    if ((v & top) != 0) begin nd = 1'b1; nv = v / 2; end
                    else nv = (v * 2) & mask;
                end else begin
                    if ((v % 2) != 0) begin nd = 1'b0; nv = (v * 2) & mask; end
                    else nv = v / 2;
                end
            end
            default: nv = v;
        endcase
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_advance();
        logic          evt;
        int unsigned   nv;
        logic          nd;
        logic [DW-1:0] ncnt;
        logic          ntick;
        evt = (step && !m_step_d) || (auto_en && m_tick);
        nv  = 32'(m_q);
        nd  = m_dir;
        if (clear) begin
            nv = 0; nd = 1'b0;
        end else if (load) begin
            nv = 32'(din); nd = 1'b0;
        end else if (evt) begin
            apply_mode(32'(m_q), 32'(mode), nv, nd);
        end
        if (clear || !auto_en) begin
            ncnt = '0; ntick = 1'b0;
        end else if (m_cnt == div) begin
            ncnt = '0; ntick = 1'b1;
        end else begin
            ncnt = m_cnt + DW'(1); ntick = 1'b0;
        end
        m_q = W'(nv); m_dir = nd; m_cnt = ncnt; m_tick = ntick; m_step_d = step;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_advance();
        exp_q.push_back(m_q);
        @(posedge clk);
        #1;
        check("q_model", 32'(q), 32'(exp_q.pop_front()));
        check("dir_model", 32'(dir), 32'(m_dir));
        check("tick_model", 32'(tick), 32'(m_tick));
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic [2:0] md);
        mode = md; din = v; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic pulse_step(input int n);
        for (int i = 0; i < n; i++) begin
            step = 1'b1; cycle();
            step = 1'b0; cycle();
        end
    endtask

    // Runs cycles until tick is seen; n is the number of cycles taken.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            n++;
            if (tick === 1'b1) break;
        end
        if (tick !== 1'b1) n = budget + 1;
    endtask

    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed then random sequence ----------------
    initial begin
        int n;
        logic [W-1:0] held;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_q", 32'(q), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;

        // Async reset in the middle of a count.
        do_load(8'h3C, 3'd0);
        auto_en = 1'b1; div = DW'(5);
        cycle(); cycle(); cycle();
        async_reset_pulse();
        wait_tick(20, n);
        check("first_tick_after_reset", 32'(n), 32'd6);
        auto_en = 1'b0;
        cycle();

        // ROL with step held high: exactly one shift.
        do_load(8'h81, 3'd3);
        step = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        step = 1'b0;
        check("rol_held_step", 32'(q), 32'h03);
        cycle();
        check("rol_no_more", 32'(q), 32'h03);

        // SHR / ASR / SHL.
        serial_in = 1'b1;
        do_load(8'h00, 3'd2);
        pulse_step(3);
        check("shr_fill1", 32'(q), 32'hE0);
        do_load(8'h80, 3'd5);
        pulse_step(2);
        check("asr", 32'(q), 32'hE0);
        serial_in = 1'b0;
        do_load(8'h81, 3'd1);
        pulse_step(1);
        check("shl_fill0", 32'(q), 32'h02);

        // Tick-driven ROR.
        do_load(8'h01, 3'd4);
        div = DW'(3); auto_en = 1'b1;
        wait_tick(20, n);
        check("ror_tick1_latency", 32'(n), 32'd4);
        cycle();
        check("ror_after_tick1", 32'(q), 32'h80);
        wait_tick(20, n);
        check("ror_tick_period", 32'(n), 32'd3);
        cycle();
        check("ror_after_tick2", 32'(q), 32'h40);
        auto_en = 1'b0;
        cycle();
        check("auto_off_tick", 32'(tick), 32'h0);
        for (int i = 0; i < 6; i++) cycle();
        check("auto_off_freeze", 32'(q), 32'h40);

        // BOUNCE.
        do_load(8'h01, 3'd6);
        pulse_step(7);
        check("bounce7_q", 32'(q), 32'h80);
        check("bounce7_dir", 32'(dir), 32'h0);
        pulse_step(1);
        check("bounce8_q", 32'(q), 32'h40);
        check("bounce8_dir", 32'(dir), 32'h1);
        pulse_step(6);
        check("bounce14_q", 32'(q), 32'h01);
        pulse_step(1);
        check("bounce15_q", 32'(q), 32'h02);
        check("bounce15_dir", 32'(dir), 32'h0);

        // Simultaneous clear + load + tick.
        mode = 3'd3; div = DW'(2); auto_en = 1'b1;
        wait_tick(20, n);
        clear = 1'b1; load = 1'b1; din = 8'hFF;
        cycle();
        clear = 1'b0; load = 1'b0;
        check("clear_wins", 32'(q), 32'h0);
        wait_tick(20, n);
        check("clear_restarts_count", 32'(n), 32'd3);
        auto_en = 1'b0;
        cycle();

        // Load beats a coincident step event.
        mode = 3'd3; din = 8'h5A; load = 1'b1; step = 1'b1;
        cycle();
        load = 1'b0; step = 1'b0;
        check("load_beats_step", 32'(q), 32'h5A);
        cycle();

        // Reserved mode holds.
        mode = 3'd7;
        pulse_step(1);
        check("mode7_hold", 32'(q), 32'h5A);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            clear     = ($urandom_range(0, 19) == 0);
            load      = ($urandom_range(0, 9) == 0);
            din       = W'($urandom);
            mode      = 3'($urandom_range(0, 7));
            serial_in = 1'($urandom);
            step      = 1'($urandom);
            if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
            if (!auto_en && $urandom_range(0, 3) == 0) div = DW'($urandom_range(0, 4));
            if (i == 200) begin
                held = q;
                async_reset_pulse();
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
